ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one read/write port of a synchronous block RAM (1-cycle read latency, enable plus write-enable) among N requesters using round-robin arbitration.
- After reset, an optional sequencer clears every RAM location before arbitration begins.
- Sits between client logic and one port of a dual-port RAM; the other RAM port stays free for an independent datapath.

Parameters:
- N, 4, number of requesters (2..8)
- AW, 6, RAM address width; depth = 2**AW
- DW, 16, RAM data width
- INIT_VALUE, 0, DW-bit word written to every address during the clear sweep

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester access request; held until granted
- we  input  N  per-requester write flag; qualifies req
- addr  input  N*AW  flattened addresses; requester i at [i*AW +: AW]
- wdata  input  N*DW  flattened write data; requester i at [i*DW +: DW]
- gnt  output  N  one-hot grant, combinational; access accepted when req[i] & gnt[i]
- busy  output  1  high while the clear sweep runs
- rdata  output  DW  read data, registered pass-through of ram_do
- rvalid  output  1  rdata valid for one cycle
- rid  output  log2(N) (min 1)  index of the requester that owns rdata
- ram_en  output  1  RAM port enable
- ram_we  output  1  RAM port write enable
- ram_addr  output  AW  RAM port address
- ram_di  output  DW  RAM port write data
- ram_do  input  DW  RAM port read data; valid the cycle after ram_en with ram_we=0

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - state = INIT if RAM_ARB_INIT_EN is defined, else ARB
  - init counter = 0; rr pointer = N-1, so requester 0 has top priority first
  - rvalid = 0, rid = 0, rdata = 0
  - gnt = 0 while rst is high
- State INIT:
  - gnt = 0, busy = 1
  - ram_en = 1, ram_we = 1, ram_addr = init counter, ram_di = INIT_VALUE
  - Counter increments every cycle; on the cycle it equals 2**AW-1, next state is ARB
  - Sweep takes exactly 2**AW cycles
- State ARB:
  - busy = 0
  - Grant goes to the first i with req[i]=1, searching from (ptr+1) mod N upward with wrap
  - At most one gnt bit is set; gnt = 0 when req = 0
  - ram_en = |gnt
  - ram_we, ram_addr, ram_di are muxed combinationally from the granted requester
  - With no grant: ram_addr = 0, ram_di = 0, ram_we = 0
  - ptr <= granted index on every grant; ptr is unchanged when idle
- Throughput: one access per cycle, back-to-back; a single requester holding req is granted every cycle.
- Read return:
  - A granted read in cycle t gives, in cycle t+1: rvalid = 1, rid = index, rdata = ram_do (registered)
  - Writes never raise rvalid
- Fairness: with all N requesting continuously, each requester is granted exactly once every N cycles.
- Requests during INIT are held off (gnt = 0) and are not lost; requesters keep req high.
- Reset mid-sweep restarts the counter at 0.
- Reset in the cycle after a read grant suppresses that rvalid.
- Same-address traffic on the other RAM port is outside this block's scope; no collision checking.

Optional Feature:
- Macro RAM_ARB_INIT_EN.
- Defined: INIT state and clear sweep are present as described above.
- Undefined: INIT state, counter and INIT_VALUE logic are removed; busy is tied to 0; arbitration starts the first cycle after rst deasserts.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding typedef (INIT, ARB)
  - function clog2 for the rid/ptr width
  - default constants for N, AW, DW
- One natural sub-module: rr_arbiter (req, ptr in; one-hot gnt and encoded index out; purely combinational), reusable elsewhere.

Test Plan:
- Init sweep (macro on), N=4, AW=6: deassert rst, no requests -> busy high exactly 64 cycles; ram_we=1 with ram_addr 0..63 in order; then busy=0. A later read of addr 0x2A by requester 1 returns rvalid, rid=1, rdata=0x0000.
- Round-robin fairness: all four req held with reads to addresses 0..3 -> gnt sequence 0001, 0010, 0100, 1000, 0001; each rvalid one cycle after its grant with the matching rid.
- Write then read: requester 2 writes 0xBEEF to addr 5, then requester 0 reads addr 5 next cycle -> rvalid, rid=0, rdata=0xBEEF; no rvalid for the write cycle.
- Wrap and skip: ptr=3 (last grant to 3), req=0b1010 -> grant 1, then 3, then 1.
- Reset mid-sweep: assert rst at counter=20 for 1 cycle -> sweep restarts at addr 0 and busy lasts 64 more cycles. A read granted at cycle t with rst at t+1 -> rvalid stays 0.
- Macro off: release rst with req[3] high -> gnt=1000 in the first post-reset cycle; busy is constantly 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the round-robin RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_e;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 16;

  // Index width for N requesters, never below one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap,
// returns a one-hot grant and the encoded winner index.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c_o,
  output logic [IW-1:0] idx_c_o
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (req_i[j] && !found) begin
        found      = 1'b1;
        gnt_c_o[j] = 1'b1;
        idx_c_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one block-RAM port among N requesters.
// Define RAM_ARB_INIT_EN to add a post-reset clear sweep of the whole RAM.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
`ifdef RAM_ARB_INIT_EN
  ,
  parameter logic [DW-1:0] INIT_VALUE = '0
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           we,
  input  logic [N*AW-1:0]        addr,
  input  logic [N*DW-1:0]        wdata,
  output logic [N-1:0]           gnt,
  output logic                   busy,
  output logic [DW-1:0]          rdata,
  output logic                   rvalid,
  output logic [clog2(N)-1:0]    rid,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [AW-1:0]          ram_addr,
  output logic [DW-1:0]          ram_di,
  input  logic [DW-1:0]          ram_do
);

  localparam int unsigned IW = clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] arb_idx;
  logic [N-1:0]  arb_gnt;
  logic          arb_en;
  logic          rvalid_q, rvalid_d;
  logic [IW-1:0] rid_q;

`ifdef RAM_ARB_INIT_EN
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep every address once, then hand the port to the arbiter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == '1) state_d = ARB;
    end
  end

  assign arb_en = (state_q == ARB) && !rst;
  assign busy   = (state_q == INIT);
`else
  assign arb_en = !rst;
  assign busy   = 1'b0;
`endif

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_c_o (arb_gnt),
    .idx_c_o (arb_idx)
  );

  assign gnt = arb_en ? arb_gnt : '0;

  // RAM port mux: idle drives zeros, the sweep overrides the arbiter.
  always_comb begin
    ram_en   = |gnt;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i]) begin
        ram_we   = we[i];
        ram_addr = addr[i*AW +: AW];
        ram_di   = wdata[i*DW +: DW];
      end
    end
`ifdef RAM_ARB_INIT_EN
    if (state_q == INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = cnt_q;
      ram_di   = INIT_VALUE;
    end
`endif
    rvalid_d = (|gnt) && !(|(gnt & we));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= IW'(N - 1);
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      if (|gnt) ptr_q <= arb_idx;
      rvalid_q <= rvalid_d;
      if (rvalid_d) rid_q <= arb_idx;
    end
  end

  // A reset in the return cycle kills the pending read response.
  assign rvalid = rvalid_q && !rst;
  assign rid    = rid_q;
  assign rdata  = rvalid ? ram_do : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 1-cycle RAM;
// follows RAM_ARB_INIT_EN to decide whether the clear sweep is expected.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we, gnt;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic            busy, rvalid, ram_en, ram_we;
  logic [DW-1:0]   rdata, ram_di, ram_do;
  logic [1:0]      rid;
  logic [AW-1:0]   ram_addr;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] exp_mem [2**AW];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  ram_port_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .busy(busy), .rdata(rdata), .rvalid(rvalid), .rid(rid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [DW-1:0] pre_word(input int a);
    return DW'(32'hA000 + a);
  endfunction

  // Behavioural synchronous RAM, preloaded with a non-zero pattern.
  initial begin
    for (int a = 0; a < 2**AW; a++) mem[a] = pre_word(a);
    ram_do = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        else        ram_do <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic rd(input int i, input int a);
    req[i] = 1'b1;
    we[i]  = 1'b0;
    addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int i, input int a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = 1'b1;
    addr[i*AW +: AW]  = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic push_rd(input int i, input int a);
    exp_t e;
    e.id   = i;
    e.data = exp_mem[a];
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic sweep();
    for (int c = 0; c < 2**AW; c++) begin
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_we", 32'(ram_we), 32'd1);
      chk("sweep_addr", 32'(ram_addr), 32'(c));
      chk("sweep_gnt", 32'(gnt), 32'd0);
      tick();
    end
  endtask

  // Monitor: pops one expected response per rvalid and flags late ones.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rid %0d rdata %0h, required no rvalid", rid, rdata);
      end else begin
        e = sb.pop_front();
        chk("rid", 32'(rid), 32'(e.id));
        chk("rdata", 32'(rdata), 32'(e.data));
        chk("rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rvalid: got none, required rid %0d in cycle %0d", e.id, e.due);
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
`ifdef RAM_ARB_INIT_EN
      exp_mem[a] = '0;
`else
      exp_mem[a] = pre_word(a);
`endif
    end
    rst = 1'b1;
    clr();
    rd(3, 7);
    tick();
    chk("gnt_in_reset", 32'(gnt), 32'd0);
    chk("rvalid_reset", 32'(rvalid), 32'd0);
    chk("rid_reset", 32'(rid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
`ifdef RAM_ARB_INIT_EN
    for (int c = 0; c <= 20; c++) begin
      chk("sweep1_addr", 32'(ram_addr), 32'(c));
      chk("sweep1_busy", 32'(busy), 32'd1);
      chk("sweep1_gnt", 32'(gnt), 32'd0);
      if (c < 20) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    sweep();
`endif
    chk("busy_after_reset", 32'(busy), 32'd0);
    chk("first_grant", 32'(gnt), 32'b1000);
    push_rd(3, 7);
    tick();
    clr();

    // Wrap and skip: ptr at 3, requesters 1 and 3 alternate.
    rd(1, 'h2A);
    rd(3, 'h11);
    #1;
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (k % 2 == 0) ? 1 : 3;
      chk("wrap_gnt", 32'(gnt), 32'(1) << id);
      push_rd(id, (id == 1) ? 'h2A : 'h11);
      tick();
    end
    clr();

    // Fairness: all four requesting continuously.
    for (int i = 0; i < 4; i++) rd(i, i);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      push_rd(k % 4, k % 4);
      tick();
    end
    clr();

    // Write then read of the same address.
    wr(2, 5, 16'hBEEF);
    #1;
    chk("wr_gnt", 32'(gnt), 32'b0100);
    chk("wr_ram_en", 32'(ram_en), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'd5);
    chk("wr_ram_di", 32'(ram_di), 32'hBEEF);
    exp_mem[5] = 16'hBEEF;
    tick();
    clr();
    rd(0, 5);
    #1;
    chk("rd_after_wr_gnt", 32'(gnt), 32'b0001);
    chk("no_rvalid_for_write", 32'(rvalid), 32'd0);
    push_rd(0, 5);
    tick();
    clr();
    #1;
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_ram_en", 32'(ram_en), 32'd0);
    chk("idle_ram_we", 32'(ram_we), 32'd0);
    chk("idle_ram_addr", 32'(ram_addr), 32'd0);
    chk("idle_ram_di", 32'(ram_di), 32'd0);
    tick();

    // Reset in the return cycle suppresses rvalid.
    rd(0, 1);
    #1;
    chk("pre_reset_gnt", 32'(gnt), 32'b0001);
    tick();
    clr();
    rst = 1'b1;
    #1;
    chk("rvalid_suppressed", 32'(rvalid), 32'd0);
    chk("gnt_during_reset", 32'(gnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
`ifdef RAM_ARB_INIT_EN
    sweep();
`endif
    chk("busy_final", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) rd(i, i);
    #1;
    chk("ptr_after_reset", 32'(gnt), 32'b0001);
    push_rd(0, 0);
    tick();
    clr();
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
